// File: rtl/axi_lite_reg_responder.sv
// AXI4-Lite subordinate exposing a bank of 32-bit control/status registers.
// Write address and write data are captured independently; a write commits
// once both are held and the B channel is free. Reads have one outstanding
// beat. Every register is exported flat on regs.
module axi_lite_reg_responder #(
    parameter int unsigned ADDR_WIDTH  = 29,
    parameter int unsigned REG_COUNT   = 16,
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic [ADDR_WIDTH-1:0]     s_awaddr,
    input  logic [2:0]                s_awprot,
    input  logic                      s_awvalid,
    output logic                      s_awready,

    input  logic [31:0]               s_wdata,
    input  logic [3:0]                s_wstrb,
    input  logic                      s_wvalid,
    output logic                      s_wready,

    output logic [1:0]                s_bresp,
    output logic                      s_bvalid,
    input  logic                      s_bready,

    input  logic [ADDR_WIDTH-1:0]     s_araddr,
    input  logic [2:0]                s_arprot,
    input  logic                      s_arvalid,
    output logic                      s_arready,

    output logic [31:0]               s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rvalid,
    input  logic                      s_rready,

    output logic [32*REG_COUNT-1:0]   regs
);

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned IDX_W    = ADDR_WIDTH - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Register storage
    logic [DATA_W-1:0] mem [REG_COUNT];

    // Write holding registers; "held" is the inverse of the ready outputs
    logic [IDX_W-1:0]  aw_idx_q;
    logic [DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;

    logic              aw_hs_c;
    logic              w_hs_c;
    logic              commit_c;
    logic              b_done_c;
    logic              aw_in_range_c;

    logic              ar_hs_c;
    logic              r_done_c;
    logic [IDX_W-1:0]  ar_idx_c;
    logic              ar_in_range_c;
    logic [DATA_W-1:0] rd_val_c;

    // Protection bits and byte offset carry no meaning for this bank
    logic              unused_c;
    assign unused_c = ^{s_awprot, s_arprot, s_awaddr[1:0], s_araddr[1:0]};

    // Handshake and commit qualifiers
    always_comb begin
        aw_hs_c       = s_awvalid & s_awready;
        w_hs_c        = s_wvalid & s_wready;
        commit_c      = ~s_awready & ~s_wready & ~s_bvalid;
        b_done_c      = s_bvalid & s_bready;
        aw_in_range_c = 64'(aw_idx_q) < 64'(REG_COUNT);
        ar_hs_c       = s_arvalid & s_arready;
        r_done_c      = s_rvalid & s_rready;
        ar_idx_c      = s_araddr[ADDR_WIDTH-1:2];
        ar_in_range_c = 64'(ar_idx_c) < 64'(REG_COUNT);
    end

    // Read mux; out-of-range indices fall through to zero
    always_comb begin
        rd_val_c = '0;
        for (int k = 0; k < int'(REG_COUNT); k++) begin
            if (ar_in_range_c && (ar_idx_c == IDX_W'(k))) begin
                rd_val_c = mem[k];
            end
        end
    end

    // Write address holding register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_awready <= 1'b1;
            aw_idx_q  <= '0;
        end else if (aw_hs_c) begin
            s_awready <= 1'b0;
            aw_idx_q  <= s_awaddr[ADDR_WIDTH-1:2];
        end else if (commit_c) begin
            s_awready <= 1'b1;
        end
    end

    // Write data holding register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_wready <= 1'b1;
            w_data_q <= '0;
            w_strb_q <= '0;
        end else if (w_hs_c) begin
            s_wready <= 1'b0;
            w_data_q <= s_wdata;
            w_strb_q <= s_wstrb;
        end else if (commit_c) begin
            s_wready <= 1'b1;
        end
    end

    // B channel: raised on commit, held until accepted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_bvalid <= 1'b0;
            s_bresp  <= RESP_OKAY;
        end else if (commit_c) begin
            s_bvalid <= 1'b1;
            s_bresp  <= aw_in_range_c ? RESP_OKAY : RESP_SLVERR;
        end else if (b_done_c) begin
            s_bvalid <= 1'b0;
        end
    end

    // Byte-strobed register update on commit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(REG_COUNT); k++) begin
                mem[k] <= RESET_VALUE;
            end
        end else if (commit_c && aw_in_range_c) begin
            for (int k = 0; k < int'(REG_COUNT); k++) begin
                if (aw_idx_q == IDX_W'(k)) begin
                    for (int b = 0; b < int'(STRB_W); b++) begin
                        if (w_strb_q[b]) begin
                            mem[k][8*b +: 8] <= w_data_q[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read channel: single outstanding beat, data captured at AR handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_arready <= 1'b1;
            s_rvalid  <= 1'b0;
            s_rdata   <= '0;
            s_rresp   <= RESP_OKAY;
        end else if (ar_hs_c) begin
            s_arready <= 1'b0;
            s_rvalid  <= 1'b1;
            s_rdata   <= rd_val_c;
            s_rresp   <= ar_in_range_c ? RESP_OKAY : RESP_SLVERR;
        end else if (r_done_c) begin
            s_arready <= 1'b1;
            s_rvalid  <= 1'b0;
        end
    end

    // Flat export of register contents
    for (genvar gk = 0; gk < int'(REG_COUNT); gk++) begin : g_regs
        assign regs[32*gk +: 32] = mem[gk];
    end

endmodule

// File: doc/axi_lite_reg_responder.md
Name: axi_lite_reg_responder

Overview:
AXI4-Lite responder (subordinate) for a bank of 32-bit control/status registers. It is the far end of the core's AXI initiator port and is mapped inside the AXI window at 0xE000_0000. It accepts single-beat reads and writes with byte strobes and exports every register flat to the fabric. Every response completes well inside the core's 17-cycle bus timeout.

Parameters:
ADDR_WIDTH, 29, byte-address bits seen on the AXI bus
REG_COUNT, 16, number of 32-bit registers (1..256)
RESET_VALUE, 32'h0000_0000, reset value of every register

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
s_awaddr  in  ADDR_WIDTH  write address
s_awprot  in  3  ignored
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_wdata  in  32  write data
s_wstrb  in  4  byte strobes; bit i enables byte [8i+7:8i]
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_araddr  in  ADDR_WIDTH  read address
s_arprot  in  3  ignored
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_rdata  out  32  read data
s_rresp  out  2  read response
s_rvalid  out  1  read data valid
s_rready  in  1  read data ready
regs  out  32*REG_COUNT  register contents; register k is regs[32k+31:32k]

Behaviour:
- Clocking and reset: one clock. rst_n is synchronous and active-low. In reset: all registers = RESET_VALUE; awready=wready=arready=1; bvalid=rvalid=0; bresp=rresp=0; rdata=0; holding flags cleared. Reset mid-transaction drops any pending beat or response without warning.
- Decode: index = addr[ADDR_WIDTH-1:2]. addr[1:0] is ignored (no alignment error). index >= REG_COUNT is out of range.
- Write address and write data are accepted independently, each into its own holding register.
  - awready = !aw_held; wready = !w_held.
  - A handshake sets the matching held flag on that edge.
  - Both may handshake in the same cycle. Either may arrive first, with an unbounded gap.
- Write commit happens on the edge where aw_held & w_held & !bvalid.
  - In range: each byte with strobe=1 is written; other bytes are unchanged. wstrb=0 gives a no-op with OKAY.
  - Out of range: no register changes; bresp=SLVERR.
  - On the commit edge: bvalid<=1 and both held flags clear.
  - Latency: with AW and W handshaking together on edge E0, commit is at E1 and bvalid is visible after E1.
- B channel: bvalid holds, with bresp stable, until the bvalid&bready edge, then clears.
  - A new commit may not happen while bvalid=1. Back-pressure on B therefore stalls AW/W once both holding registers are full.
- Read path supports a single outstanding read. arready = !rvalid.
  - On the AR handshake edge: rdata <= reg[index] (0 if out of range), rresp = OKAY or SLVERR, rvalid <= 1.
  - rdata and rresp stay stable until the rvalid&rready edge, then rvalid clears.
  - The next AR is accepted the cycle after rvalid clears. Back-to-back throughput is one read per 2 cycles.
- Read/write collision: if an AR handshake and a write commit to the same register fall on the same edge, rdata returns the old value. The write and read paths are otherwise fully independent.
- regs reflects register state directly; a committed write is visible on regs the cycle after the commit edge.
- Worst-case latency with ready held high: write response 2 edges after the later of AW/W; read response 1 edge after AR.

Test Plan:
- Reset, then AW(0x08)+W(0xDEADBEEF, strb 4'hF) in the same cycle with bready=1 -> bvalid high exactly 2 edges later with bresp=00; regs[95:64]=0xDEADBEEF; a read of 0x08 returns 0xDEADBEEF, rresp=00, rvalid 1 edge after AR.
- W first, AW 5 cycles later (addr 0x04, data 0x11223344, strb 4'b0101) onto a register holding 0xAABBCCDD -> wready low during the gap; register becomes 0xAA22CC44; single B response.
- Write to 0x40 and read of 0x44 with REG_COUNT=16 -> bresp=SLVERR with no register change; rdata=0 with rresp=SLVERR.
- bready held low for 10 cycles while two writes are issued -> first bvalid stays high with stable bresp; second AW/W are captured, then awready=wready=0 until the first B handshake; the second B follows 1 edge later; both writes land.
- rready held low for 4 cycles -> arready=0 and rdata stable throughout; the next AR is accepted the cycle after the R handshake.
- Same-edge AR and write commit to reg 3 (old 0x1, new 0x2) -> rdata=0x1; a subsequent read returns 0x2. Assert rst_n=0 while bvalid=1 -> next cycle bvalid=0 and all regs=RESET_VALUE.
